ram_seq_ctrl: RTL and testbench

RAM_SEQ_CTRL -- requirements
Module: ram_seq_ctrl

---
 rtl/ram_seq_ctrl_if.sv | 33 +++
 rtl/ram_seq_ctrl.sv | 114 +++++++++++
 tb/tb_ram_seq_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_seq_ctrl_if.sv
// Bundle of command, fill/dump stream and RAM-drive signals for ram_seq_ctrl.
interface ram_seq_ctrl_if #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 10
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_base;
  logic [ADDR_WIDTH-1:0] cmd_len;
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_ready;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport master (
    output cmd_valid, cmd_op, cmd_base, cmd_len, wr_valid, wr_data, rd_ready, ram_dout,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, ram_addr, ram_din, ram_we
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_base, cmd_len, wr_valid, wr_data, rd_ready, ram_dout,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/ram_seq_ctrl.sv
// Burst fill/dump sequencer for a single-port block RAM with 1-cycle read latency.
module ram_seq_ctrl #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 10
) (
  input logic           clk,
  input logic           rst,
  ram_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, DUMP} state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE_A = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, remaining, addr_q;
  logic                  issue_done, done_q, inflight_p1;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  fifo_rd, fifo_wr;
  logic [1:0]            fifo_cnt;
  logic [2:0]            occ;
  logic                  accept, wr_fire, issue, pop, last_wr, last_pop;

  assign bus.rd_valid = (fifo_cnt != 2'd0);
  assign bus.rd_data  = fifo_mem[fifo_rd];
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, stream handshakes, RAM drive and read-issue decision.
  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    wr_fire       = 1'b0;
    issue         = 1'b0;
    pop           = 1'b0;
    last_wr       = 1'b0;
    last_pop      = 1'b0;
    occ           = 3'd0;
    bus.cmd_ready = 1'b0;
    bus.wr_ready  = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_din   = '0;
    bus.ram_addr  = addr_q;
    unique case (state)
      IDLE: begin
        // The done cycle is spent in IDLE but commands wait one more cycle.
        bus.cmd_ready = !done_q;
        accept        = bus.cmd_valid && !done_q;
        if (accept) state_nxt = bus.cmd_op ? DUMP : FILL;
      end
      FILL: begin
        bus.wr_ready = 1'b1;
        bus.ram_addr = ptr;
        bus.ram_din  = bus.wr_data;
        // Gate with rst so an aborted fill cannot write in the reset cycle.
        wr_fire      = bus.wr_valid && !rst;
        bus.ram_we   = wr_fire;
        last_wr      = wr_fire && (remaining == '0);
        if (last_wr) state_nxt = IDLE;
      end
      DUMP: begin
        pop   = bus.rd_valid && bus.rd_ready;
        occ   = {1'b0, fifo_cnt} + {2'b00, inflight_p1} - {2'b00, pop};
        issue = !issue_done && (occ < 3'd2);
        if (issue) bus.ram_addr = ptr;
        last_pop = pop && issue_done && !inflight_p1 && (fifo_cnt == 2'd1);
        if (last_pop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: pointer, word counter, read-in-flight flag, FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      remaining   <= '0;
      addr_q      <= '0;
      issue_done  <= 1'b0;
      done_q      <= 1'b0;
      inflight_p1 <= 1'b0;
      fifo_rd     <= 1'b0;
      fifo_wr     <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      done_q      <= last_wr || last_pop;
      addr_q      <= bus.ram_addr;
      // p0 -> p1: read address presented, RAM data returns next cycle.
      inflight_p1 <= issue;
      if (accept) begin
        ptr        <= bus.cmd_base;
        remaining  <= bus.cmd_len;
        issue_done <= 1'b0;
      end else if (wr_fire || issue) begin
        ptr <= ptr + ONE_A;
        if (remaining == '0) issue_done <= 1'b1;
        else                 remaining  <= remaining - ONE_A;
      end
      if (inflight_p1) fifo_wr <= ~fifo_wr;
      if (pop)         fifo_rd <= ~fifo_rd;
      fifo_cnt <= fifo_cnt + {1'b0, inflight_p1} - {1'b0, pop};
    end
  end

  // p1 -> FIFO: capture RAM read data one cycle after the read was issued.
  always_ff @(posedge clk) begin
    if (inflight_p1) fifo_mem[fifo_wr] <= bus.ram_dout;
  end
endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Directed bench for ram_seq_ctrl with a behavioural read-old-data RAM.
module tb_ram_seq_ctrl;
  localparam int DW = 18;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  logic [DW-1:0] ram_mem [1 << AW];
  logic [DW-1:0] shadow  [1 << AW];

  ram_seq_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_seq_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single-port RAM, registered read returning old data on a same-address write.
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= ram_mem[bus.ram_addr];
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy_pat(input int c);
    if ((c >= 1 && c <= 5) || (c >= 10 && c <= 14)) return 1'b0;
    if (c < 30 && (c % 3) == 2) return 1'b0;
    return 1'b1;
  endfunction

  task automatic start_cmd(input logic op, input logic [AW-1:0] base,
                           input logic [AW-1:0] len, input bit keep);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_base  = base;
    bus.cmd_len   = len;
    #1;
    chk("cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    if (!keep) bus.cmd_valid = 1'b0;
    chk("busy_accept", {31'd0, bus.busy}, 32'd1);
  endtask

  task automatic do_fill(input logic [AW-1:0] base, input logic [AW-1:0] len,
                         input logic [DW-1:0] seed);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    start_cmd(1'b0, base, len, 1'b0);
    for (int i = 0; i <= int'(len); i++) begin
      a = base + AW'(i);
      d = seed + DW'(i);
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      #1;
      chk("fill_we",   {31'd0, bus.ram_we}, 32'd1);
      chk("fill_addr", 32'(bus.ram_addr), 32'(a));
      chk("fill_din",  32'(bus.ram_din), 32'(d));
      shadow[a] = d;
      tick();
    end
    #1;
    chk("fill_done",   {31'd0, bus.done}, 32'd1);
    chk("fill_busy",   {31'd0, bus.busy}, 32'd0);
    chk("fill_we_off", {31'd0, bus.ram_we}, 32'd0);
    chk("fill_cmdrdy", {31'd0, bus.cmd_ready}, 32'd0);
    bus.wr_valid = 1'b0;
    tick();
    chk("fill_done_end", {31'd0, bus.done}, 32'd0);
    chk("fill_cmdrdy2",  {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  // Runs from DUMP entry until the done cycle; returns in the done cycle.
  task automatic dump_check(input logic [AW-1:0] base, input int n, input int mode,
                            input bit hold_cmd);
    int            k   = 0;
    bit            fin = 1'b0;
    bit            pv  = 1'b0;
    bit            pr  = 1'b0;
    logic [DW-1:0] pd  = '0;
    logic [AW-1:0] a;
    for (int c = 0; c < 200 && !fin; c++) begin
      bus.rd_ready = (mode == 0) ? 1'b1 : rdy_pat(c);
      #1;
      if (bus.done) begin
        chk("dump_words", 32'(k), 32'(n));
        chk("dump_busy",  {31'd0, bus.busy}, 32'd0);
        chk("dump_rdv",   {31'd0, bus.rd_valid}, 32'd0);
        if (hold_cmd) chk("hold_rdy_done", {31'd0, bus.cmd_ready}, 32'd0);
        fin = 1'b1;
      end else begin
        chk("fifo_le2", {31'd0, (dut.fifo_cnt <= 2'd2)}, 32'd1);
        if (hold_cmd) chk("hold_rdy", {31'd0, bus.cmd_ready}, 32'd0);
        if (pv && !pr) begin
          chk("stall_vld",  {31'd0, bus.rd_valid}, 32'd1);
          chk("stall_data", 32'(bus.rd_data), 32'(pd));
        end
        if (bus.rd_valid && bus.rd_ready) begin
          a = base + AW'(k);
          chk("rd_data", 32'(bus.rd_data), 32'(shadow[a]));
          k++;
        end
        pv = bus.rd_valid;
        pr = bus.rd_ready;
        pd = bus.rd_data;
        tick();
      end
    end
    if (!fin) chk("dump_timeout", 32'd0, 32'd1);
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_cmdrdy", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst_done",   {31'd0, bus.done}, 32'd0);
    chk("rst_rdv",    {31'd0, bus.rd_valid}, 32'd0);
    chk("rst_we",     {31'd0, bus.ram_we}, 32'd0);
    chk("rst_addr",   32'(bus.ram_addr), 32'd0);
    chk("rst_din",    32'(bus.ram_din), 32'd0);
    tick();

    // Fill 0x010..0x013 with 1,2,3,4.
    do_fill(10'h010, 10'd3, 18'd1);

    // Dump it back with rd_ready high: data on E+2..E+5, done at E+6.
    start_cmd(1'b1, 10'h010, 10'd3, 1'b0);
    bus.rd_ready = 1'b1;
    #1;
    chk("dump_e0_rdv", {31'd0, bus.rd_valid}, 32'd0);
    tick();
    chk("dump_e1_rdv", {31'd0, bus.rd_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fast_rdv",  {31'd0, bus.rd_valid}, 32'd1);
      chk("fast_data", 32'(bus.rd_data), 32'(i + 1));
    end
    tick();
    chk("fast_done", {31'd0, bus.done}, 32'd1);
    chk("fast_busy", {31'd0, bus.busy}, 32'd0);
    bus.rd_ready = 1'b0;
    tick();

    // Address wrap from 0x3FF to 0x000, data crossing the all-ones boundary.
    do_fill(10'h3FE, 10'd3, 18'h3FFFD);
    start_cmd(1'b1, 10'h3FE, 10'd3, 1'b0);
    dump_check(10'h3FE, 4, 0, 1'b0);
    tick();

    // Eight-word dump under a stalling consumer.
    do_fill(10'h100, 10'd7, 18'h15550);
    start_cmd(1'b1, 10'h100, 10'd7, 1'b0);
    dump_check(10'h100, 8, 1, 1'b0);
    tick();

    // Reset in the middle of a fill, on the third word.
    start_cmd(1'b0, 10'h200, 10'd7, 1'b0);
    for (int i = 0; i < 2; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 18'h00A00 + DW'(i);
      #1;
      chk("abort_we_pre", {31'd0, bus.ram_we}, 32'd1);
      shadow[10'h200 + AW'(i)] = 18'h00A00 + DW'(i);
      tick();
    end
    bus.wr_data = 18'h00A02;
    rst = 1'b1;
    #1;
    chk("abort_we_rst", {31'd0, bus.ram_we}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_busy",   {31'd0, bus.busy}, 32'd0);
    chk("abort_we",     {31'd0, bus.ram_we}, 32'd0);
    chk("abort_done",   {31'd0, bus.done}, 32'd0);
    chk("abort_cmdrdy", {31'd0, bus.cmd_ready}, 32'd1);
    bus.wr_valid = 1'b0;
    tick();
    chk("abort_done2", {31'd0, bus.done}, 32'd0);

    // A new command runs normally; the aborted region holds only two words.
    do_fill(10'h300, 10'd0, 18'd7);
    start_cmd(1'b1, 10'h200, 10'd1, 1'b0);
    dump_check(10'h200, 2, 0, 1'b0);
    tick();

    // cmd_valid held through a dump: accepted only after the done cycle.
    start_cmd(1'b1, 10'h010, 10'd3, 1'b1);
    dump_check(10'h010, 4, 0, 1'b1);
    tick();
    chk("hold_rdy_after", {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("hold_accepted", {31'd0, bus.busy}, 32'd1);
    dump_check(10'h010, 4, 0, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
